// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with stall, flush and a
// saturating count of entries discarded by flush.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic              STALL,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [7:0]        DROP_CNT
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, pop;
  logic [1:0]        held;
  logic [8:0]        drop_sum;

  // Ready depends only on registered state and STALL, never on OUT_READY.
  assign IN_READY  = (state != S_FULL) && !STALL;
  assign OUT_VALID = ((state == S_ONE) || (state == S_FULL)) && !STALL;
  assign OUT_DATA  = main_data;
  assign OUT_CTRL  = OUT_VALID ? main_ctrl : '0;

  assign accept = IN_VALID && IN_READY;
  assign pop    = OUT_VALID && OUT_READY;

  always_comb begin
    held = 2'd0;
    if (state == S_ONE)  held = 2'd1;
    if (state == S_FULL) held = 2'd2;
  end

  assign drop_sum = {1'b0, DROP_CNT} + {7'b0, held};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      DROP_CNT  <= '0;
    end else if (FLUSH) begin
      state    <= S_EMPTY;
      DROP_CNT <= drop_sum[8] ? 8'hff : drop_sum[7:0];
    end else begin
      // STALL needs no branch: it already forces accept and pop low.
      case (state)
        S_EMPTY: begin
          if (accept) begin
            main_data <= IN_DATA;
            main_ctrl <= IN_CTRL;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_data <= IN_DATA;
            main_ctrl <= IN_CTRL;
          end else if (accept) begin
            skid_data <= IN_DATA;
            skid_ctrl <= IN_CTRL;
            state     <= S_FULL;
          end else if (pop) begin
            state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, checked
// against a FIFO-queue model of the stage.
module tb_pipe_stage_reg;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RESET, IN_VALID, IN_READY, STALL, FLUSH, OUT_VALID, OUT_READY;
  logic [DW-1:0] IN_DATA, OUT_DATA;
  logic [CW-1:0] IN_CTRL, OUT_CTRL;
  logic [7:0]    DROP_CNT;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL), .STALL(STALL), .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_CTRL(OUT_CTRL), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            m_drop;
  logic [DW-1:0] last_head;
  int            total = 0;
  int            bad = 0;
  bit            chk_en = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check before the edge, advance model.
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic ordy,
                      input logic st, input logic fl, input logic rs);
    logic [DW-1:0] d;
    logic e_rdy, e_vld, acc, pp;
    ent_t e;
    @(negedge CLK);
    d = {$urandom, $urandom, $urandom, $urandom};
    IN_VALID = iv; IN_CTRL = ic; IN_DATA = d; OUT_READY = ordy;
    STALL = st; FLUSH = fl; RESET = rs;
    #1;
    e_rdy = (q.size() < 2) && !st;
    e_vld = (q.size() > 0) && !st;
    if (chk_en) begin
      chk("in_ready",  IN_READY,  e_rdy);
      chk("out_valid", OUT_VALID, e_vld);
      chk("out_ctrl",  OUT_CTRL,  e_vld ? q[0].c : '0);
      chk("out_data",  OUT_DATA,  (q.size() > 0) ? q[0].d : last_head);
      chk("drop_cnt",  DROP_CNT,  m_drop);
    end
    acc = iv && e_rdy;
    pp  = e_vld && ordy;
    @(posedge CLK);
    if (!rs) begin
      q.delete(); m_drop = 0; last_head = '0;
    end else if (fl) begin
      m_drop = (m_drop + q.size() > 255) ? 255 : m_drop + q.size();
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.c = ic; e.d = d;
        q.push_back(e);
      end
    end
    if (q.size() > 0) last_head = q[0].d;
    chk_en = 1;
  endtask

  initial begin
    q.delete(); m_drop = 0; last_head = '0;
    IN_VALID = 0; IN_CTRL = '0; IN_DATA = '0; OUT_READY = 0;
    STALL = 0; FLUSH = 0; RESET = 0;

    // reset, then idle cycle checks reset state and IN_READY=1
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // streaming 1..4 with OUT_READY=1
    for (int i = 1; i <= 4; i++) step(1, CW'(i), 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);

    // backpressure: A, B fill; C waits until ready
    step(1, 16'h00a, 0, 0, 0, 1);
    step(1, 16'h00b, 0, 0, 0, 1);
    step(1, 16'h00c, 0, 0, 0, 1);
    step(1, 16'h00c, 1, 0, 0, 1);
    step(1, 16'h00c, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);

    // flush of FULL with a concurrent offer
    step(0, 0, 0, 0, 0, 0);
    step(1, 16'h011, 0, 0, 0, 1);
    step(1, 16'h022, 0, 0, 0, 1);
    step(1, 16'h033, 1, 0, 1, 1);
    #1;
    chk("flush_drop2", DROP_CNT, 2);
    chk("flush_bubble", OUT_VALID, 0);
    chk("flush_ctrl0", OUT_CTRL, 0);
    step(0, 0, 1, 0, 0, 1);

    // stall while holding X
    step(1, 16'h0bee, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 16'h0dad, 1, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);

    // saturate the drop counter, then reset
    for (int i = 0; i < 130; i++) begin
      step(1, CW'(i), 0, 0, 0, 1);
      step(1, CW'(i + 1), 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 1);
    end
    #1;
    chk("drop_sat", DROP_CNT, 255);
    step(1, 16'h1, 0, 0, 0, 1);
    step(1, 16'h2, 0, 0, 1, 1);
    #1;
    chk("drop_hold255", DROP_CNT, 255);
    step(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_drop0", DROP_CNT, 0);
    chk("rst_vld0", OUT_VALID, 0);
    chk("rst_rdy1", IN_READY, 1);

    // reset in FULL together with FLUSH must not count drops
    step(1, 16'h5, 0, 0, 0, 1);
    step(1, 16'h6, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    #1;
    chk("rst_flush_drop0", DROP_CNT, 0);

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 49) != 0);
    step(0, 0, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
